// File: rtl/asym_byte_to_word_fifo_if.sv
// Producer/consumer bus of the byte-in / word-out FIFO.
// The master modport drives pushes, pops and flush; the slave modport is the FIFO.
interface asym_byte_to_word_fifo_if #(
   parameter int WIDTHA     = 8,
   parameter int WIDTHB     = 32,
   parameter int ADDRWIDTHB = 6
);
   logic                  clr;
   logic                  wr_en;
   logic [WIDTHA-1:0]     wr_data;
   logic                  full;
   logic                  rd_en;
   logic [WIDTHB-1:0]     rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic [ADDRWIDTHB:0]   word_count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output clr, wr_en, wr_data, rd_en,
      input  full, rd_data, rd_valid, empty, word_count, overflow, underflow
   );

   modport slave (
      input  clr, wr_en, wr_data, rd_en,
      output full, rd_data, rd_valid, empty, word_count, overflow, underflow
   );
endinterface

// File: rtl/asym_byte_to_word_fifo.sv
// Single-clock FIFO: bytes pushed on the narrow side, packed little-endian words popped on the wide side.
// Flags are registered from the post-update byte count so they are clean for the next cycle.
module asym_byte_to_word_fifo #(
   parameter int WIDTHA     = 8,
   parameter int SIZEA      = 256,
   parameter int ADDRWIDTHA = 8,
   parameter int WIDTHB     = 32,
   parameter int SIZEB      = 64,
   parameter int ADDRWIDTHB = 6
) (
   input logic                    clk,
   input logic                    rst,
   asym_byte_to_word_fifo_if.slave bus
);
   localparam int RATIO = WIDTHB / WIDTHA;
   localparam int LOG2R = $clog2(RATIO);

   typedef logic [ADDRWIDTHA:0] bytePtr_t;
   typedef logic [ADDRWIDTHB:0] wordPtr_t;

   logic [WIDTHA-1:0] ram [SIZEB*RATIO];

   bytePtr_t          wptr, wptrNext, byteCntNext;
   wordPtr_t          rptr, rptrNext;
   logic              pushOk, popOk;
   logic [WIDTHB-1:0] rdWord;

   assign pushOk      = bus.wr_en && !bus.full;
   assign popOk       = bus.rd_en && !bus.empty;
   assign wptrNext    = wptr + bytePtr_t'(pushOk);
   assign rptrNext    = rptr + wordPtr_t'(popOk);
   // Word pointer scaled to bytes; wrap bits line up so the difference is the true occupancy.
   assign byteCntNext = wptrNext - {rptrNext, {LOG2R{1'b0}}};

   // Lowest byte address lands in the least significant lane.
   for (genvar k = 0; k < RATIO; k++) begin : gLane
      assign rdWord[k*WIDTHA +: WIDTHA] = ram[{rptr[ADDRWIDTHB-1:0], LOG2R'(k)}];
   end

   always_ff @(posedge clk) begin
      if (pushOk && !bus.clr)
         ram[wptr[ADDRWIDTHA-1:0]] <= bus.wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr           <= '0;
         rptr           <= '0;
         bus.full       <= 1'b0;
         bus.empty      <= 1'b1;
         bus.word_count <= '0;
         bus.overflow   <= 1'b0;
         bus.underflow  <= 1'b0;
         bus.rd_valid   <= 1'b0;
         bus.rd_data    <= '0;
      end else if (bus.clr) begin
         // Flush wins over this cycle's push/pop; rd_data keeps its last word.
         wptr           <= '0;
         rptr           <= '0;
         bus.full       <= 1'b0;
         bus.empty      <= 1'b1;
         bus.word_count <= '0;
         bus.overflow   <= 1'b0;
         bus.underflow  <= 1'b0;
         bus.rd_valid   <= 1'b0;
      end else begin
         wptr           <= wptrNext;
         rptr           <= rptrNext;
         bus.full       <= (byteCntNext == bytePtr_t'(SIZEA));
         bus.empty      <= (byteCntNext < bytePtr_t'(RATIO));
         bus.word_count <= byteCntNext[ADDRWIDTHA:LOG2R];
         bus.rd_valid   <= popOk;
         if (popOk)
            bus.rd_data <= rdWord;
         if (bus.wr_en && bus.full)
            bus.overflow <= 1'b1;
         if (bus.rd_en && bus.empty)
            bus.underflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_asym_byte_to_word_fifo.sv
// Byte-queue reference model checked against the FIFO every cycle, plus directed literal checks.
module tb_asym_byte_to_word_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   asym_byte_to_word_fifo_if #(.WIDTHA(8), .WIDTHB(32), .ADDRWIDTHB(6)) bus ();

   asym_byte_to_word_fifo #(
      .WIDTHA(8), .SIZEA(256), .ADDRWIDTHA(8),
      .WIDTHB(32), .SIZEB(64), .ADDRWIDTHB(6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference state: stored bytes in arrival order, plus sticky flags and the last popped word.
   byte unsigned q[$];
   logic         mOv = 1'b0;
   logic         mUn = 1'b0;
   logic         mRv = 1'b0;
   logic [31:0]  mRd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      int  pre;
      if (rst) begin
         q.delete();
         mOv = 1'b0; mUn = 1'b0; mRv = 1'b0; mRd = '0;
      end else if (bus.clr) begin
         q.delete();
         mOv = 1'b0; mUn = 1'b0; mRv = 1'b0;
      end else begin
         pre = q.size();
         mRv = 1'b0;
         if (bus.wr_en && pre == 256) mOv = 1'b1;
         if (bus.rd_en && pre < 4)    mUn = 1'b1;
         if (bus.rd_en && pre >= 4) begin
            mRd = {q[3], q[2], q[1], q[0]};
            mRv = 1'b1;
            repeat (4) void'(q.pop_front());
         end
         if (bus.wr_en && pre != 256)
            q.push_back(bus.wr_data);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("empty",      32'(bus.empty),      32'(q.size() < 4));
         chk("full",       32'(bus.full),       32'(q.size() == 256));
         chk("word_count", 32'(bus.word_count), 32'(q.size() / 4));
         chk("overflow",   32'(bus.overflow),   32'(mOv));
         chk("underflow",  32'(bus.underflow),  32'(mUn));
         chk("rd_valid",   32'(bus.rd_valid),   32'(mRv));
         chk("rd_data",    bus.rd_data,         mRd);
      end
   end

   task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit c);
      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.rd_en   = re;
      bus.clr     = c;
      @(negedge clk);
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.clr = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_empty",  32'(bus.empty), 32'd1);
      chk("rst_full",   32'(bus.full),  32'd0);
      chk("rst_wc",     32'(bus.word_count), 32'd0);
      chk("rst_rdata",  bus.rd_data, 32'h0);
      chk("rst_rvalid", 32'(bus.rd_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Word packing and pop latency
      cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0); cyc(1, 8'h44, 0, 0);
      chk("t1_empty_before", 32'(bus.empty), 32'd0);
      cyc(0, 8'h00, 1, 0);
      chk("t1_data",   bus.rd_data, 32'h44332211);
      chk("t1_valid",  32'(bus.rd_valid), 32'd1);
      chk("t1_empty",  32'(bus.empty), 32'd1);
      chk("t1_wc",     32'(bus.word_count), 32'd0);

      // Partial word stays hidden
      cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0); cyc(1, 8'h03, 0, 0);
      cyc(0, 8'h00, 1, 0);
      chk("t2_empty",  32'(bus.empty), 32'd1);
      chk("t2_valid",  32'(bus.rd_valid), 32'd0);
      chk("t2_under",  32'(bus.underflow), 32'd1);
      cyc(1, 8'h04, 0, 0);
      chk("t2_empty4", 32'(bus.empty), 32'd0);
      chk("t2_wc",     32'(bus.word_count), 32'd1);
      cyc(0, 8'h00, 0, 1);
      chk("t2_clr_under", 32'(bus.underflow), 32'd0);

      // Fill, overflow, drain
      for (int i = 0; i < 256; i++) cyc(1, 8'($urandom), 0, 0);
      chk("t3_full", 32'(bus.full), 32'd1);
      chk("t3_wc",   32'(bus.word_count), 32'd64);
      cyc(1, 8'hAA, 0, 0);
      chk("t3_over", 32'(bus.overflow), 32'd1);
      chk("t3_wc2",  32'(bus.word_count), 32'd64);
      for (int i = 0; i < 64; i++) cyc(0, 8'h00, 1, 0);
      chk("t3_empty", 32'(bus.empty), 32'd1);
      chk("t3_wc0",   32'(bus.word_count), 32'd0);

      // Pointer wrap
      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 200; i++) cyc(1, 8'($urandom), 0, 0);
      for (int i = 0; i < 50; i++)  cyc(0, 8'h00, 1, 0);
      for (int i = 0; i < 200; i++) cyc(1, 8'($urandom), 0, 0);
      chk("t4_wc", 32'(bus.word_count), 32'd50);
      for (int i = 0; i < 50; i++)  cyc(0, 8'h00, 1, 0);
      chk("t4_empty", 32'(bus.empty), 32'd1);

      // Concurrent push and pop
      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 128; i++) cyc(1, 8'($urandom), 0, 0);
      chk("t5_wc_start", 32'(bus.word_count), 32'd32);
      for (int i = 0; i < 8; i++) cyc(1, 8'($urandom), 1, 0);
      chk("t5_wc_end", 32'(bus.word_count), 32'd26);

      // Flush beats a simultaneous push and pop
      cyc(1, 8'h5A, 1, 1);
      chk("t6_empty", 32'(bus.empty), 32'd1);
      chk("t6_wc",    32'(bus.word_count), 32'd0);
      chk("t6_valid", 32'(bus.rd_valid), 32'd0);
      chk("t6_full",  32'(bus.full), 32'd0);

      // Async reset in the middle of a pop
      cyc(1, 8'hDE, 0, 0); cyc(1, 8'hAD, 0, 0); cyc(1, 8'hBE, 0, 0); cyc(1, 8'hEF, 0, 0);
      bus.wr_en = 1'b0; bus.rd_en = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_pop_valid", 32'(bus.rd_valid), 32'd1);
      chk("t6_pop_data",  bus.rd_data, 32'hEFBEADDE);
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(bus.rd_valid), 32'd0);
      chk("t6_rst_data",  bus.rd_data, 32'h0);
      chk("t6_rst_empty", 32'(bus.empty), 32'd1);
      bus.rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Random traffic: fill-biased then drain-biased
      for (int i = 0; i < 3000; i++) begin
         int wp;
         wp = (i < 1500) ? 8 : 3;
         cyc($urandom_range(0, 9) < wp, 8'($urandom), $urandom_range(0, 9) < 4,
             $urandom_range(0, 299) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
